uart_dbus_bridge: RTL and testbench

UART-to-dBus debug bridge: decodes byte frames from a host on the serial link and issues single-word read/write commands as a dBus initiator. It drives the same simple dBus command/response interface the VexRiscv core uses. It therefore reaches RAM and the IO register space without involving the CPU. It sits between the `uart_lite` RX/TX byte ports and a dBus arbiter input.

---
 rtl/uart_dbus_bridge_if.sv | 26 ++
 rtl/uart_dbus_bridge.sv | 192 +++++++++++++++++++
 tb/tb_uart_dbus_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_dbus_bridge_if.sv
// uart_dbus_bridge_if: single-word dBus command/response bundle, as seen by a VexRiscv-style dBus port.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; responses are unconditional single-cycle rsp_ready pulses.
// Signals: cmd_valid, cmd_ready, cmd_payload_{wr,address,data,size}, rsp_ready, rsp_error, rsp_data.
// Modports: master = command initiator (the bridge), slave = arbiter / memory side.
interface uart_dbus_bridge_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_payload_wr;
   logic [31:0] cmd_payload_address;
   logic [31:0] cmd_payload_data;
   logic [1:0]  cmd_payload_size;
   logic        rsp_ready;
   logic        rsp_error;
   logic [31:0] rsp_data;

   modport master (
      output cmd_valid, cmd_payload_wr, cmd_payload_address, cmd_payload_data, cmd_payload_size,
      input  cmd_ready, rsp_ready, rsp_error, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_payload_wr, cmd_payload_address, cmd_payload_data, cmd_payload_size,
      output cmd_ready, rsp_ready, rsp_error, rsp_data
   );
endinterface

// File: rtl/uart_dbus_bridge.sv
// uart_dbus_bridge: decodes UART byte frames into single-word dBus reads/writes and replies over UART.
// Latency: cmd_valid the cycle after the last frame byte; first reply byte no earlier than 2 cycles after handshake.
// Backpressure: command held stable until cmd_ready; reply bytes wait for tx_rdy; rx bytes outside a frame are dropped.
// Ports: clk/resetn; rx_valid/rx_data from UART RX; tx_rdy/tx_vld/tx_data to UART TX; dbus (master); busy.
// Build option: define UART_DBUS_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYCLES without a byte.
module uart_dbus_bridge #(
   parameter int unsigned CLK_FREQ           = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES     = CLK_FREQ / 100,
   parameter int unsigned RSP_TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   input  logic               tx_rdy,
   output logic               tx_vld,
   output logic [7:0]         tx_data,
   output logic               busy,
   uart_dbus_bridge_if.master dbus
);
   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RPL_OK  = 8'h4B;
   localparam logic [7:0] RPL_ERR = 8'h45;
   localparam logic [7:0] RPL_TO  = 8'h54;
   localparam logic [7:0] RPL_BAD = 8'h3F;
   localparam int         RSP_W   = $clog2(RSP_TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_CMD, S_WAIT_RSP, S_SEND
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic             wr_q, wr_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      tx_buf_q, tx_buf_d;     // reply bytes, next byte in [31:24]
   logic [2:0]       tx_cnt_q, tx_cnt_d;     // reply bytes still to send
   logic             tx_gap_q, tx_gap_d;     // blocks tx_rdy sampling for one cycle
   logic [RSP_W-1:0] rsp_cnt_q, rsp_cnt_d;
   logic             tx_fire;
   logic             ib_expired;

`ifdef UART_DBUS_TIMEOUT_EN
   localparam int IB_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IB_W-1:0] ib_cnt_q, ib_cnt_d;
   logic            in_frame;

   assign in_frame   = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
   // A byte arriving in the expiry cycle still wins over the abort.
   assign ib_expired = in_frame && !rx_valid && (ib_cnt_q == IB_W'(TIMEOUT_CYCLES));

   always_comb begin
      ib_cnt_d = '0;
      if (in_frame && !rx_valid) ib_cnt_d = ib_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ib_cnt_q <= '0;
      else         ib_cnt_q <= ib_cnt_d;
   end
`else
   // Without the inter-byte timer a partial frame waits for its remaining bytes forever.
   assign ib_expired = 1'b0;
   // TIMEOUT_CYCLES stays a parameter so both builds share one instantiation.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   // Gap after a launch (and on entry to SEND) gives the UART a cycle to drop tx_rdy.
   assign tx_fire = (state_q == S_SEND) && tx_rdy && !tx_gap_q;
   assign tx_vld  = tx_fire;
   assign tx_data = tx_buf_q[31:24];
   assign busy    = (state_q != S_IDLE);

   assign dbus.cmd_valid           = (state_q == S_CMD);
   assign dbus.cmd_payload_wr      = wr_q;
   assign dbus.cmd_payload_address = addr_q;
   assign dbus.cmd_payload_data    = data_q;
   assign dbus.cmd_payload_size    = 2'b10;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      tx_buf_d   = tx_buf_q;
      tx_cnt_d   = tx_cnt_q;
      tx_gap_d   = 1'b0;
      rsp_cnt_d  = rsp_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                  wr_d       = (rx_data == OP_WR);
                  byte_cnt_d = '0;
                  state_d    = S_GET_ADDR;
               end else begin
                  tx_buf_d = {RPL_BAD, 24'h0};
                  tx_cnt_d = 3'd1;
                  tx_gap_d = 1'b1;
                  state_d  = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (rx_valid) begin
               addr_d     = {addr_q[23:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = wr_q ? S_GET_DATA : S_CMD;
            end
         end
         S_GET_DATA: begin
            if (rx_valid) begin
               data_d     = {data_q[23:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (dbus.cmd_ready) begin
               if (wr_q) begin
                  tx_buf_d = {RPL_OK, 24'h0};
                  tx_cnt_d = 3'd1;
                  tx_gap_d = 1'b1;
                  state_d  = S_SEND;
               end else begin
                  rsp_cnt_d = '0;
                  state_d   = S_WAIT_RSP;
               end
            end
         end
         S_WAIT_RSP: begin
            rsp_cnt_d = rsp_cnt_q + 1'b1;
            if (dbus.rsp_ready) begin
               if (dbus.rsp_error) begin
                  tx_buf_d = {RPL_ERR, 24'h0};
                  tx_cnt_d = 3'd1;
               end else begin
                  tx_buf_d = dbus.rsp_data;
                  tx_cnt_d = 3'd4;
               end
               tx_gap_d = 1'b1;
               state_d  = S_SEND;
            end else if (rsp_cnt_q == RSP_W'(RSP_TIMEOUT_CYCLES - 1)) begin
               tx_buf_d = {RPL_TO, 24'h0};
               tx_cnt_d = 3'd1;
               tx_gap_d = 1'b1;
               state_d  = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_fire) begin
               tx_buf_d = {tx_buf_q[23:0], 8'h00};
               tx_cnt_d = tx_cnt_q - 3'd1;
               tx_gap_d = 1'b1;
               if (tx_cnt_q == 3'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (ib_expired) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         tx_buf_q   <= '0;
         tx_cnt_q   <= '0;
         tx_gap_q   <= 1'b0;
         rsp_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         tx_buf_q   <= tx_buf_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_gap_q   <= tx_gap_d;
         rsp_cnt_q  <= rsp_cnt_d;
      end
   end
endmodule

// File: tb/tb_uart_dbus_bridge.sv
// tb_uart_dbus_bridge: directed vector table plus hand sequences for stall, response timeout, frame abort and reset.
// Latency: n/a.
// Backpressure: drives cmd_ready stalls and a gated tx_rdy pattern.
module tb_uart_dbus_bridge;
   localparam int TO  = 64;
   localparam int RTO = 1024;

   logic       clk;
   logic       resetn;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_rdy;
   logic       tx_vld;
   logic [7:0] tx_data;
   logic       busy;

   uart_dbus_bridge_if dbus();

   uart_dbus_bridge #(
      .CLK_FREQ(100000000), .TIMEOUT_CYCLES(TO), .RSP_TIMEOUT_CYCLES(RTO)
   ) dut (
      .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_data(tx_data), .busy(busy), .dbus(dbus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } cmd_t;

   typedef struct {
      string       name;
      int          nb;
      logic [7:0]  b[9];
      int          rsp_mode;   // 0 none, 1 data, 2 error
      logic [31:0] rsp_word;
      bit          pre_err;    // hold rsp_ready/error high until the real response
      bit          gate;       // tx_rdy high only one cycle in three
      int          exp_ncmd;
      logic        exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      bit          chk_data;
      int          exp_ntx;
      logic [7:0]  exp_tx[4];
   } vec_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   cmd_t        cmd_q[$];
   logic [7:0]  tx_q[$];
   int          tx_cyc_q[$];
   int          hs_cyc = 0;
   int          valid_cycles = 0;
   int          gate_viol = 0;
   int          rd_hs_cnt = 0;
   int          ncyc = 0;
   logic        prev_tx_vld = 1'b0;
   int          rsp_mode = 0;
   logic [31:0] rsp_word = 32'h0;
   bit          pre_err = 1'b0;
   bit          gate = 1'b0;
   int          served_cnt = 0;
   int          rdy_cyc = 0;
   vec_t        vecs[6];

   // Observer: records tx pulses, command handshakes and TX protocol violations.
   initial begin
      cmd_t c;
      forever begin
         @(negedge clk);
         ncyc++;
         if (tx_vld) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(ncyc);
            if (!tx_rdy || prev_tx_vld) gate_viol++;
         end
         prev_tx_vld = tx_vld;
         if (dbus.cmd_valid) begin
            valid_cycles++;
            if (dbus.cmd_ready) begin
               c.wr   = dbus.cmd_payload_wr;
               c.addr = dbus.cmd_payload_address;
               c.data = dbus.cmd_payload_data;
               c.size = dbus.cmd_payload_size;
               cmd_q.push_back(c);
               hs_cyc = ncyc;
               if (!c.wr) rd_hs_cnt++;
            end
         end
      end
   end

   // UART transmitter model: always ready, or ready one cycle in three.
   initial begin
      tx_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         rdy_cyc++;
         tx_rdy = gate ? ((rdy_cyc % 3) == 0) : 1'b1;
      end
   end

   // dBus responder: answers a read one cycle after its handshake.
   initial begin
      dbus.rsp_ready = 1'b0;
      dbus.rsp_error = 1'b0;
      dbus.rsp_data  = 32'h0;
      forever begin
         @(posedge clk); #1;
         dbus.rsp_ready = pre_err;
         dbus.rsp_error = pre_err;
         dbus.rsp_data  = 32'h0;
         if (rd_hs_cnt != served_cnt) begin
            served_cnt = rd_hs_cnt;
            if (rsp_mode != 0) begin
               dbus.rsp_ready = 1'b1;
               dbus.rsp_error = (rsp_mode == 2);
               dbus.rsp_data  = rsp_word;
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: bench did not finish within 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Caller is #1 after a rising edge; returns #1 after the edge following the byte cycle.
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, 32'(busy), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      int tb0 = tx_q.size();
      int cb0 = cmd_q.size();
      int vb0 = valid_cycles;
      int gb0 = gate_viol;
      int ncmd;
      int ntx;
      gate     = v.gate;
      rsp_mode = v.rsp_mode;
      rsp_word = v.rsp_word;
      pre_err  = v.pre_err;
      for (int i = 0; i < v.nb; i++) send_byte(v.b[i]);
      wait_idle(v.name, 3000);
      repeat (4) @(posedge clk);
      #1;
      ncmd = cmd_q.size() - cb0;
      ntx  = tx_q.size() - tb0;
      check({v.name, "_ncmd"}, ncmd, v.exp_ncmd);
      check({v.name, "_valid_cycles"}, valid_cycles - vb0, v.exp_ncmd);
      if (ncmd >= 1 && v.exp_ncmd >= 1) begin
         check({v.name, "_wr"}, 32'(cmd_q[cb0].wr), 32'(v.exp_wr));
         check({v.name, "_addr"}, cmd_q[cb0].addr, v.exp_addr);
         check({v.name, "_size"}, 32'(cmd_q[cb0].size), 32'h2);
         if (v.chk_data) check({v.name, "_data"}, cmd_q[cb0].data, v.exp_data);
      end
      check({v.name, "_ntx"}, ntx, v.exp_ntx);
      for (int j = 0; j < v.exp_ntx && j < ntx; j++)
         check({v.name, $sformatf("_tx%0d", j)}, 32'(tx_q[tb0 + j]), 32'(v.exp_tx[j]));
      check({v.name, "_tx_protocol"}, gate_viol - gb0, 0);
      if (v.exp_wr && ncmd == 1 && ntx >= 1)
         check({v.name, "_k_after_2"}, 32'((tx_cyc_q[tb0] - hs_cyc) >= 2), 32'h1);
      gate     = 1'b0;
      pre_err  = 1'b0;
      rsp_mode = 0;
   endtask

   initial begin
      int tb0, cb0, vb0, unstable, d;
      cmd_t snap;

      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      dbus.cmd_ready = 1'b1;

      vecs[0] = '{"write", 9, '{8'h57, 8'h80, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0F},
                  0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 32'h8000000C, 32'h0000000F, 1'b1, 1,
                  '{8'h4B, 8'h00, 8'h00, 8'h00}};
      vecs[1] = '{"read", 5, '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 32'hDEADBEEF, 1'b0, 1'b1, 1, 1'b0, 32'h00000010, 32'h0, 1'b0, 4,
                  '{8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      vecs[2] = '{"read_err", 5, '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00},
                  2, 32'hDEADBEEF, 1'b0, 1'b0, 1, 1'b0, 32'h00000010, 32'h0, 1'b0, 1,
                  '{8'h45, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{"bad_op", 1, '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1,
                  '{8'h3F, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{"write_after_bad", 9, '{8'h57, 8'h12, 8'h34, 8'h56, 8'h7B, 8'hAA, 8'hBB, 8'hCC, 8'hDD},
                  0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 32'h1234567B, 32'hAABBCCDD, 1'b1, 1,
                  '{8'h4B, 8'h00, 8'h00, 8'h00}};
      vecs[5] = '{"read_rsp_in_hs", 5, '{8'h52, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 32'hCAFEF00D, 1'b1, 1'b0, 1, 1'b0, 32'h00000003, 32'h0, 1'b0, 4,
                  '{8'hCA, 8'hFE, 8'hF0, 8'h0D}};

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_vld",   32'(tx_vld), 32'h0);
      check("rst_tx_data",  32'(tx_data), 32'h0);
      check("rst_cmd_valid", 32'(dbus.cmd_valid), 32'h0);
      check("rst_wr",       32'(dbus.cmd_payload_wr), 32'h0);
      check("rst_addr",     dbus.cmd_payload_address, 32'h0);
      check("rst_data",     dbus.cmd_payload_data, 32'h0);
      check("rst_size",     32'(dbus.cmd_payload_size), 32'h2);
      check("rst_busy",     32'(busy), 32'h0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 6; k++) run_vec(vecs[k]);

      // Command stall with rx bytes injected while the command waits.
      tb0 = tx_q.size(); cb0 = cmd_q.size(); vb0 = valid_cycles; unstable = 0;
      dbus.cmd_ready = 1'b0;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check("bp_valid_rise", 32'(dbus.cmd_valid), 32'h1);
      snap.wr = dbus.cmd_payload_wr; snap.addr = dbus.cmd_payload_address;
      snap.data = dbus.cmd_payload_data; snap.size = dbus.cmd_payload_size;
      for (int i = 0; i < 21; i++) begin
         rx_valid = (i % 5 == 2);
         rx_data  = 8'h52;
         if (i == 20) dbus.cmd_ready = 1'b1;
         @(negedge clk);
         if (!dbus.cmd_valid || dbus.cmd_payload_wr !== snap.wr || dbus.cmd_payload_address !== snap.addr ||
             dbus.cmd_payload_data !== snap.data || dbus.cmd_payload_size !== snap.size) unstable++;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      check("bp_valid_drop", 32'(dbus.cmd_valid), 32'h0);
      check("bp_unstable_cycles", unstable, 0);
      wait_idle("bp", 200);
      repeat (4) @(posedge clk);
      #1;
      check("bp_valid_cycles", valid_cycles - vb0, 21);
      check("bp_ncmd", cmd_q.size() - cb0, 1);
      if (cmd_q.size() > cb0) begin
         check("bp_addr", cmd_q[cb0].addr, 32'h00000020);
         check("bp_data", cmd_q[cb0].data, 32'h11223344);
         check("bp_wr", 32'(cmd_q[cb0].wr), 32'h1);
      end
      check("bp_ntx", tx_q.size() - tb0, 1);
      if (tx_q.size() > tb0) check("bp_tx0", 32'(tx_q[tb0]), 32'h4B);

      // Read that never gets a response.
      tb0 = tx_q.size(); cb0 = cmd_q.size();
      rsp_mode = 0;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
      wait_idle("rsp_to", RTO + 200);
      repeat (4) @(posedge clk);
      #1;
      check("rsp_to_ncmd", cmd_q.size() - cb0, 1);
      check("rsp_to_ntx", tx_q.size() - tb0, 1);
      if (tx_q.size() > tb0) begin
         check("rsp_to_tx0", 32'(tx_q[tb0]), 32'h54);
         d = tx_cyc_q[tb0] - hs_cyc;
         n_cmp++;
         if (d < RTO || d > RTO + 4) begin
            n_fail++;
            $display("FAIL rsp_to_latency: actual=%0d cycles required=%0d..%0d", d, RTO, RTO + 4);
         end
      end

      // Partial frame followed by silence.
      tb0 = tx_q.size(); cb0 = cmd_q.size();
      send_byte(8'h52); send_byte(8'h00);
      repeat (TO + 20) @(posedge clk);
      #1;
`ifdef UART_DBUS_TIMEOUT_EN
      check("ib_to_busy", 32'(busy), 32'h0);
      check("ib_to_ncmd", cmd_q.size() - cb0, 0);
      check("ib_to_ntx", tx_q.size() - tb0, 0);
`else
      check("ib_wait_busy", 32'(busy), 32'h1);
      rsp_mode = 2;
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h50);
      wait_idle("ib_wait", 200);
      repeat (4) @(posedge clk);
      #1;
      rsp_mode = 0;
      check("ib_wait_ncmd", cmd_q.size() - cb0, 1);
      if (cmd_q.size() > cb0) check("ib_wait_addr", cmd_q[cb0].addr, 32'h00000050);
      check("ib_wait_ntx", tx_q.size() - tb0, 1);
      if (tx_q.size() > tb0) check("ib_wait_tx0", 32'(tx_q[tb0]), 32'h45);
`endif

      // Reset in the middle of a write frame.
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h02);
      resetn = 1'b0;
      #1;
      check("mid_rst_tx_vld",    32'(tx_vld), 32'h0);
      check("mid_rst_tx_data",   32'(tx_data), 32'h0);
      check("mid_rst_cmd_valid", 32'(dbus.cmd_valid), 32'h0);
      check("mid_rst_wr",        32'(dbus.cmd_payload_wr), 32'h0);
      check("mid_rst_addr",      dbus.cmd_payload_address, 32'h0);
      check("mid_rst_data",      dbus.cmd_payload_data, 32'h0);
      check("mid_rst_busy",      32'(busy), 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      vecs[0].name = "write_after_reset";
      run_vec(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
